// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: drives one ALU command at a time, captures result/NZCV and returns a tagged response.
// Optional condition-code gating of commands is enabled by defining ALU_SEQ_COND_EN.
module alu_op_sequencer #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic [TAG_W-1:0]  cmd_tag,
  input  logic              cmd_setf,
  input  logic [3:0]        cmd_cond,
  output logic [3:0]        alu_ctrl,
  output logic [DATA_W-1:0] in_1,
  output logic [DATA_W-1:0] in_2,
  input  logic [DATA_W-1:0] alu_rslt,
  input  logic [3:0]        alu_checks,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              rsp_skipped,
  output logic [3:0]        flags_nzcv,
  output logic [CNT_W-1:0]  exec_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  state_t            state;
  state_t            state_next;
  logic [3:0]        op_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic              setf_q;
  logic              accept;
  logic              cond_pass;

  assign accept = cmd_valid && cmd_ready;

`ifdef ALU_SEQ_COND_EN
  logic flag_n, flag_z, flag_c, flag_v;
  assign {flag_n, flag_z, flag_c, flag_v} = flags_nzcv;

  // Condition is judged against the flags as they stand at the accept edge.
  always_comb begin
    cond_pass = 1'b0;
    case (cmd_cond)
      4'h0: cond_pass = flag_z;
      4'h1: cond_pass = !flag_z;
      4'h2: cond_pass = flag_c;
      4'h3: cond_pass = !flag_c;
      4'h4: cond_pass = flag_n;
      4'h5: cond_pass = !flag_n;
      4'h6: cond_pass = flag_v;
      4'h7: cond_pass = !flag_v;
      4'h8: cond_pass = flag_c && !flag_z;
      4'h9: cond_pass = !flag_c || flag_z;
      4'hA: cond_pass = (flag_n == flag_v);
      4'hB: cond_pass = (flag_n != flag_v);
      4'hC: cond_pass = !flag_z && (flag_n == flag_v);
      4'hD: cond_pass = flag_z || (flag_n != flag_v);
      4'hE: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end
`else
  logic unused_cond;
  assign unused_cond = ^cmd_cond;
  assign cond_pass   = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = cond_pass ? ISSUE : RESP;
      ISSUE:   state_next = CAPTURE;
      CAPTURE: state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outside ISSUE the ALU sees its default opcode and zero operands, so it stays deterministic.
  always_comb begin
    cmd_ready = (state == IDLE);
    rsp_valid = (state == RESP);
    alu_ctrl  = 4'b1111;
    in_1      = '0;
    in_2      = '0;
    if (state == ISSUE) begin
      alu_ctrl = op_q;
      in_1     = a_q;
      in_2     = b_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q        <= 4'b1111;
      a_q         <= '0;
      b_q         <= '0;
      setf_q      <= 1'b0;
      rsp_data    <= '0;
      rsp_tag     <= '0;
      rsp_skipped <= 1'b0;
      flags_nzcv  <= 4'b0000;
      exec_count  <= '0;
    end else begin
      if (accept) begin
        op_q        <= cmd_op;
        a_q         <= cmd_a;
        b_q         <= cmd_b;
        setf_q      <= cmd_setf;
        rsp_tag     <= cmd_tag;
        rsp_skipped <= !cond_pass;
        if (!cond_pass) rsp_data <= '0;
      end
      // ALU reports {V,Z,C,N}; the status register is kept as {N,Z,C,V}.
      if (state == CAPTURE) begin
        rsp_data   <= alu_rslt;
        exec_count <= exec_count + 1'b1;
        if (setf_q) flags_nzcv <= {alu_checks[0], alu_checks[2], alu_checks[1], alu_checks[3]};
      end
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed testbench for alu_op_sequencer with a behavioural single-register ALU attached.
// Condition-code scenarios follow the ALU_SEQ_COND_EN build of the design.
module tb_alu_op_sequencer;
  localparam int DATA_W = 32;
  localparam int TAG_W  = 4;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [3:0]        cmd_op = 4'h0;
  logic [DATA_W-1:0] cmd_a = '0;
  logic [DATA_W-1:0] cmd_b = '0;
  logic [TAG_W-1:0]  cmd_tag = '0;
  logic              cmd_setf = 1'b0;
  logic [3:0]        cmd_cond = 4'hE;
  logic [3:0]        alu_ctrl;
  logic [DATA_W-1:0] in_1;
  logic [DATA_W-1:0] in_2;
  logic [DATA_W-1:0] alu_rslt = '0;
  logic [3:0]        alu_checks = 4'b0100;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [DATA_W-1:0] rsp_data;
  logic [TAG_W-1:0]  rsp_tag;
  logic              rsp_skipped;
  logic [3:0]        flags_nzcv;
  logic [CNT_W-1:0]  exec_count;

  int errors = 0;
  int checks = 0;
  logic [CNT_W-1:0]  exp_cnt = '0;

  int                lat;
  logic [3:0]        ctrl_seen;
  logic [DATA_W-1:0] x1_seen;
  logic [DATA_W-1:0] x2_seen;

  always #5 clk = ~clk;

  alu_op_sequencer #(.DATA_W(DATA_W), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag), .cmd_setf(cmd_setf), .cmd_cond(cmd_cond),
    .alu_ctrl(alu_ctrl), .in_1(in_1), .in_2(in_2),
    .alu_rslt(alu_rslt), .alu_checks(alu_checks),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .rsp_skipped(rsp_skipped), .flags_nzcv(flags_nzcv), .exec_count(exec_count)
  );

  // ALU stand-in: 0000 ADD, 0001 SUB, 0010 AND, anything else yields zero; result registered on clk.
  always @(posedge clk) begin : alu_model
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] r;
    logic              cf;
    logic              vf;
    sum = '0;
    r   = '0;
    cf  = 1'b0;
    vf  = 1'b0;
    case (alu_ctrl)
      4'b0000: begin
        sum = {1'b0, in_1} + {1'b0, in_2};
        r   = sum[DATA_W-1:0];
        cf  = sum[DATA_W];
        vf  = (in_1[DATA_W-1] == in_2[DATA_W-1]) && (r[DATA_W-1] != in_1[DATA_W-1]);
      end
      4'b0001: begin
        r  = in_1 - in_2;
        cf = (in_1 >= in_2);
        vf = (in_1[DATA_W-1] != in_2[DATA_W-1]) && (r[DATA_W-1] != in_1[DATA_W-1]);
      end
      4'b0010: r = in_1 & in_2;
      default: r = '0;
    endcase
    alu_rslt   <= r;
    alu_checks <= {vf, (r == '0), cf, r[DATA_W-1]};
  end

  // Called and returns at a negedge; lat is the cycle (accept edge = 0) in which rsp_valid is first seen.
  task automatic issue(input logic [3:0] op, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                       input logic [TAG_W-1:0] tag, input logic setf, input logic [3:0] cond);
    int n;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_tag   = tag;
    cmd_setf  = setf;
    cmd_cond  = cond;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    ctrl_seen = alu_ctrl;
    x1_seen   = in_1;
    x2_seen   = in_2;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic retire();
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = '0;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (rsp_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_rsp_data got=%h exp=0", rsp_data); end
    checks++; if (rsp_tag !== 4'h0) begin errors++; $display("[TB] FAIL reset_rsp_tag got=%h exp=0", rsp_tag); end
    checks++; if (rsp_skipped !== 1'b0) begin errors++; $display("[TB] FAIL reset_skipped got=%b exp=0", rsp_skipped); end
    checks++; if (flags_nzcv !== 4'b0000) begin errors++; $display("[TB] FAIL reset_flags got=%b exp=0000", flags_nzcv); end
    checks++; if (exec_count !== 4'd0) begin errors++; $display("[TB] FAIL reset_count got=%0d exp=0", exec_count); end
    checks++; if (alu_ctrl !== 4'b1111) begin errors++; $display("[TB] FAIL reset_alu_ctrl got=%b exp=1111", alu_ctrl); end
    checks++; if (in_1 !== 32'h0 || in_2 !== 32'h0) begin errors++; $display("[TB] FAIL reset_operands got=%h/%h exp=0/0", in_1, in_2); end
  endtask

  task automatic test_add_overflow();
    issue(4'b0000, 32'h7FFFFFFF, 32'h1, 4'h3, 1'b1, 4'hE);
    exp_cnt = exp_cnt + 1'b1;
    checks++; if (lat != 3) begin errors++; $display("[TB] FAIL add_latency got=%0d exp=3", lat); end
    checks++; if (ctrl_seen !== 4'b0000 || x1_seen !== 32'h7FFFFFFF || x2_seen !== 32'h1) begin errors++; $display("[TB] FAIL add_issue got=%b/%h/%h exp=0000/7fffffff/00000001", ctrl_seen, x1_seen, x2_seen); end
    checks++; if (rsp_data !== 32'h80000000) begin errors++; $display("[TB] FAIL add_data got=%h exp=80000000", rsp_data); end
    checks++; if (rsp_tag !== 4'h3) begin errors++; $display("[TB] FAIL add_tag got=%h exp=3", rsp_tag); end
    checks++; if (rsp_skipped !== 1'b0) begin errors++; $display("[TB] FAIL add_skipped got=%b exp=0", rsp_skipped); end
    checks++; if (flags_nzcv !== 4'b1001) begin errors++; $display("[TB] FAIL add_flags got=%b exp=1001", flags_nzcv); end
    checks++; if (exec_count !== exp_cnt) begin errors++; $display("[TB] FAIL add_count got=%0d exp=%0d", exec_count, exp_cnt); end
    retire();
    checks++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL add_retire got ready=%b valid=%b exp ready=1 valid=0", cmd_ready, rsp_valid); end
    checks++; if (alu_ctrl !== 4'b1111) begin errors++; $display("[TB] FAIL idle_alu_ctrl got=%b exp=1111", alu_ctrl); end
  endtask

  task automatic test_sub_flags();
    issue(4'b0001, 32'h5, 32'h5, 4'h1, 1'b1, 4'hE);
    exp_cnt = exp_cnt + 1'b1;
    checks++; if (rsp_data !== 32'h0) begin errors++; $display("[TB] FAIL sub_eq_data got=%h exp=0", rsp_data); end
    checks++; if (flags_nzcv !== 4'b0110) begin errors++; $display("[TB] FAIL sub_eq_flags got=%b exp=0110", flags_nzcv); end
    retire();
    issue(4'b0010, 32'h0000FF0F, 32'h00000F0F, 4'h2, 1'b0, 4'hE);
    exp_cnt = exp_cnt + 1'b1;
    checks++; if (rsp_data !== 32'h00000F0F) begin errors++; $display("[TB] FAIL and_data got=%h exp=00000f0f", rsp_data); end
    checks++; if (flags_nzcv !== 4'b0110) begin errors++; $display("[TB] FAIL and_noset_flags got=%b exp=0110", flags_nzcv); end
    retire();
    issue(4'b0001, 32'h0, 32'h1, 4'h4, 1'b1, 4'hE);
    exp_cnt = exp_cnt + 1'b1;
    checks++; if (rsp_data !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL sub_neg_data got=%h exp=ffffffff", rsp_data); end
    checks++; if (flags_nzcv !== 4'b1000) begin errors++; $display("[TB] FAIL sub_neg_flags got=%b exp=1000", flags_nzcv); end
    retire();
    issue(4'b0001, 32'h80000000, 32'h1, 4'h6, 1'b1, 4'hE);
    exp_cnt = exp_cnt + 1'b1;
    checks++; if (rsp_data !== 32'h7FFFFFFF) begin errors++; $display("[TB] FAIL sub_ovf_data got=%h exp=7fffffff", rsp_data); end
    checks++; if (flags_nzcv !== 4'b0011) begin errors++; $display("[TB] FAIL sub_ovf_flags got=%b exp=0011", flags_nzcv); end
    checks++; if (exec_count !== exp_cnt) begin errors++; $display("[TB] FAIL sub_count got=%0d exp=%0d", exec_count, exp_cnt); end
    retire();
  endtask

  task automatic test_hold();
    issue(4'b0001, 32'h9, 32'h4, 4'h5, 1'b0, 4'hE);
    exp_cnt = exp_cnt + 1'b1;
    cmd_valid = 1'b1;
    cmd_op    = 4'b0010;
    cmd_tag   = 4'hA;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 32'h5 || rsp_tag !== 4'h5 || cmd_ready !== 1'b0)
        begin errors++; $display("[TB] FAIL hold_stable cyc=%0d got valid=%b data=%h tag=%h ready=%b exp 1/00000005/5/0", i, rsp_valid, rsp_data, rsp_tag, cmd_ready); end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    retire();
    checks++; if (exec_count !== exp_cnt) begin errors++; $display("[TB] FAIL hold_count got=%0d exp=%0d", exec_count, exp_cnt); end
    issue(4'b0000, 32'h10, 32'h20, 4'hB, 1'b0, 4'hE);
    exp_cnt = exp_cnt + 1'b1;
    checks++; if (lat != 3 || rsp_data !== 32'h30 || rsp_tag !== 4'hB) begin errors++; $display("[TB] FAIL hold_after got lat=%0d data=%h tag=%h exp 3/00000030/b", lat, rsp_data, rsp_tag); end
    retire();
  endtask

  task automatic test_back_to_back();
    issue(4'b0000, 32'h1, 32'h2, 4'h7, 1'b0, 4'hE);
    exp_cnt = exp_cnt + 1'b1;
    retire();
    issue(4'b0001, 32'h100, 32'h1, 4'h8, 1'b0, 4'hE);
    exp_cnt = exp_cnt + 1'b1;
    checks++; if (lat != 3 || rsp_data !== 32'hFF || rsp_tag !== 4'h8) begin errors++; $display("[TB] FAIL b2b_second got lat=%0d data=%h tag=%h exp 3/000000ff/8", lat, rsp_data, rsp_tag); end
    checks++; if (exec_count !== exp_cnt) begin errors++; $display("[TB] FAIL b2b_count got=%0d exp=%0d", exec_count, exp_cnt); end
    retire();
  endtask

  task automatic test_cond();
    issue(4'b0000, 32'h1, 32'h1, 4'h9, 1'b1, 4'hE);
    exp_cnt = exp_cnt + 1'b1;
    checks++; if (flags_nzcv !== 4'b0000) begin errors++; $display("[TB] FAIL cond_setup_flags got=%b exp=0000", flags_nzcv); end
    retire();
    issue(4'b0000, 32'h3, 32'h4, 4'hC, 1'b1, 4'h0);
`ifdef ALU_SEQ_COND_EN
    checks++; if (lat != 1) begin errors++; $display("[TB] FAIL cond_eq_latency got=%0d exp=1", lat); end
    checks++; if (rsp_skipped !== 1'b1 || rsp_data !== 32'h0 || rsp_tag !== 4'hC) begin errors++; $display("[TB] FAIL cond_eq_rsp got skip=%b data=%h tag=%h exp 1/00000000/c", rsp_skipped, rsp_data, rsp_tag); end
    checks++; if (ctrl_seen !== 4'b1111) begin errors++; $display("[TB] FAIL cond_eq_no_issue got=%b exp=1111", ctrl_seen); end
`else
    exp_cnt = exp_cnt + 1'b1;
    checks++; if (lat != 3) begin errors++; $display("[TB] FAIL cond_ignored_latency got=%0d exp=3", lat); end
    checks++; if (rsp_skipped !== 1'b0 || rsp_data !== 32'h7) begin errors++; $display("[TB] FAIL cond_ignored_rsp got skip=%b data=%h exp 0/00000007", rsp_skipped, rsp_data); end
`endif
    checks++; if (exec_count !== exp_cnt) begin errors++; $display("[TB] FAIL cond_eq_count got=%0d exp=%0d", exec_count, exp_cnt); end
    checks++; if (flags_nzcv !== 4'b0000) begin errors++; $display("[TB] FAIL cond_eq_flags got=%b exp=0000", flags_nzcv); end
    retire();
    issue(4'b0000, 32'h3, 32'h4, 4'hD, 1'b0, 4'h1);
    exp_cnt = exp_cnt + 1'b1;
    checks++; if (lat != 3 || rsp_skipped !== 1'b0 || rsp_data !== 32'h7) begin errors++; $display("[TB] FAIL cond_ne got lat=%0d skip=%b data=%h exp 3/0/00000007", lat, rsp_skipped, rsp_data); end
    checks++; if (exec_count !== exp_cnt) begin errors++; $display("[TB] FAIL cond_ne_count got=%0d exp=%0d", exec_count, exp_cnt); end
    retire();
  endtask

  task automatic test_default_op();
    issue(4'b1111, 32'h12345678, 32'h9ABCDEF0, 4'hE, 1'b1, 4'hE);
    exp_cnt = exp_cnt + 1'b1;
    checks++; if (rsp_data !== 32'h0 || flags_nzcv !== 4'b0100) begin errors++; $display("[TB] FAIL op1111 got data=%h flags=%b exp 00000000/0100", rsp_data, flags_nzcv); end
    retire();
    issue(4'b0000, 32'hFFFFFFFF, 32'h2, 4'h1, 1'b1, 4'hE);
    exp_cnt = exp_cnt + 1'b1;
    checks++; if (rsp_data !== 32'h1 || flags_nzcv !== 4'b0010) begin errors++; $display("[TB] FAIL add_carry got data=%h flags=%b exp 00000001/0010", rsp_data, flags_nzcv); end
    retire();
    issue(4'b1110, 32'h5, 32'h6, 4'h2, 1'b1, 4'hE);
    exp_cnt = exp_cnt + 1'b1;
    checks++; if (rsp_data !== 32'h0 || flags_nzcv !== 4'b0100) begin errors++; $display("[TB] FAIL op1110 got data=%h flags=%b exp 00000000/0100", rsp_data, flags_nzcv); end
    checks++; if (exec_count !== exp_cnt) begin errors++; $display("[TB] FAIL default_count got=%0d exp=%0d", exec_count, exp_cnt); end
    retire();
  endtask

  task automatic test_reset_mid_op();
    logic seen_valid;
    cmd_valid = 1'b1;
    cmd_op    = 4'b0000;
    cmd_a     = 32'h2;
    cmd_b     = 32'h3;
    cmd_tag   = 4'hF;
    cmd_setf  = 1'b1;
    cmd_cond  = 4'hE;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = '0;
    checks++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_state got ready=%b valid=%b exp 1/0", cmd_ready, rsp_valid); end
    checks++; if (flags_nzcv !== 4'b0000 || exec_count !== 4'd0) begin errors++; $display("[TB] FAIL midrst_regs got flags=%b count=%0d exp 0000/0", flags_nzcv, exec_count); end
    seen_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      seen_valid = seen_valid | rsp_valid;
    end
    rsp_ready = 1'b0;
    checks++; if (seen_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_no_rsp got=%b exp=0", seen_valid); end
  endtask

  task automatic test_count_wrap();
    for (int i = 0; i < 16; i++) begin
      issue(4'b0000, i, 32'h1, i[TAG_W-1:0], 1'b0, 4'hE);
      exp_cnt = exp_cnt + 1'b1;
      checks++; if (exec_count !== exp_cnt || rsp_data !== i + 1) begin errors++; $display("[TB] FAIL wrap_op%0d got count=%0d data=%h exp %0d/%h", i, exec_count, rsp_data, exp_cnt, i + 1); end
      retire();
    end
    checks++; if (exec_count !== 4'd0) begin errors++; $display("[TB] FAIL wrap_final got=%0d exp=0", exec_count); end
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_sub_flags();
    test_hold();
    test_back_to_back();
    test_cond();
    test_default_op();
    test_reset_mid_op();
    test_count_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
